// File: rtl/qam_pkg.sv
// Shared 64-QAM definitions used by the capture stage, the symbol FIFO and the
// constellation mapper.
//   QAM_SYM_W : width of one 64-QAM symbol index (log2 of 64)
//   qam_sym_t : one symbol index
package qam_pkg;

    localparam int QAM_SYM_W = 6;

    typedef logic [QAM_SYM_W-1:0] qam_sym_t;

endpackage : qam_pkg

// File: rtl/qam_fifo_ram.sv
// Storage array for qam_symbol_fifo: DEPTH x DATA_W entries, one write port and
// one registered read port. The array itself is never reset. Only the read
// output register is cleared, so the FIFO's rd_data reset value is defined.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (read register only)
//   we_i     : write strobe, stores wdata_i at waddr_i
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read strobe, captures mem[raddr_i] into rdata_o
//   raddr_i  : read address
//   rdata_o  : registered read data, holds its value when re_i is low
module qam_fifo_ram
    import qam_pkg::*;
#(
    parameter int DATA_W = QAM_SYM_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The FIFO never reads and writes the same entry in one cycle: that would
    // need count to be both 0 and DEPTH. No bypass is therefore needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : qam_fifo_ram

// File: rtl/qam_symbol_fifo.sv
// Synchronous FIFO buffering 64-QAM symbol indices between the input capture
// stage and the constellation mapper. Single clock domain. All status outputs
// are registered and computed from the next-state occupancy, so they agree
// with the pointers in the cycle after each update.
// Optional build macro: QAM_FIFO_ERR_FLAGS_EN adds the sticky overflow and
// underflow outputs. Without it, dropped requests are silent.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   wr_en       : write request, accepted when not full
//   wr_data     : symbol to write
//   rd_en       : read request, accepted when not empty
//   rd_data     : registered read symbol (1 clk after an accepted read)
//   rd_valid    : rd_data holds a newly read symbol this cycle
//   full        : count == DEPTH
//   empty       : count == 0
//   almost_full : count >= AF_LEVEL
//   count       : occupancy 0..DEPTH
//   overflow    : (macro only) sticky, set by wr_en while full
//   underflow   : (macro only) sticky, set by rd_en while empty
module qam_symbol_fifo
    import qam_pkg::*;
#(
    parameter int DATA_W   = QAM_SYM_W,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
`ifdef QAM_FIFO_ERR_FLAGS_EN
    output logic                     overflow,
    output logic                     underflow,
`endif
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full_q, empty_q, almost_full_q, rd_valid_q;
    logic             wr_acc, rd_acc;

    // Acceptance uses the registered flags, i.e. the state before this edge.
    // This gives the required read-only-when-full and write-only-when-empty
    // behaviour for simultaneous requests without any fall-through path.
    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q + CNT_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + CNT_W'(rd_acc);
        count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= (count_d == DEPTH_C);
            empty_q       <= (count_d == '0);
            almost_full_q <= (count_d >= AF_C);
            rd_valid_q    <= rd_acc;
        end
    end

    // Pointers carry one extra wrap bit; only the low bits address storage.
    qam_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_data)
    );

`ifdef QAM_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign rd_valid    = rd_valid_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = almost_full_q;
    assign count       = count_q;

endmodule : qam_symbol_fifo

// File: tb/tb_qam_symbol_fifo.sv
// Self-checking bench for qam_symbol_fifo (DEPTH=16, AF_LEVEL=12, DATA_W=6).
// A queue-based reference model tracks the stored symbols; a compare process
// checks every DUT output against it on each falling edge, and the stimulus
// sequence adds literal expectations for the directed scenarios.
module tb_qam_symbol_fifo;

    localparam int DW    = 6;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [4:0]    count;
`ifdef QAM_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int checks   = 0;
    int failures = 0;

    qam_symbol_fifo #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
`ifdef QAM_FIFO_ERR_FLAGS_EN
        .overflow    (overflow),
        .underflow   (underflow),
`endif
        .almost_full (almost_full),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a plain queue, plus the last read symbol.
    logic [DW-1:0] mq [$];
    logic [DW-1:0] m_data;
    logic          m_vld;
    logic          m_ovf;
    logic          m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_data <= '0;
            m_vld  <= 1'b0;
            m_ovf  <= 1'b0;
            m_unf  <= 1'b0;
        end else begin
            if (wr_en && mq.size() == DEPTH) m_ovf <= 1'b1;
            if (rd_en && mq.size() == 0)     m_unf <= 1'b1;
            m_vld <= rd_en && (mq.size() > 0);
            if (wr_en && rd_en && mq.size() > 0 && mq.size() < DEPTH) begin
                m_data <= mq.pop_front();
                mq.push_back(wr_data);
            end else if (rd_en && mq.size() > 0) begin
                m_data <= mq.pop_front();
            end else if (wr_en && mq.size() < DEPTH) begin
                mq.push_back(wr_data);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_count",    int'(count),       mq.size());
            check("cmp_full",     int'(full),        int'(mq.size() == DEPTH));
            check("cmp_empty",    int'(empty),       int'(mq.size() == 0));
            check("cmp_afull",    int'(almost_full), int'(mq.size() >= AF));
            check("cmp_rd_valid", int'(rd_valid),    int'(m_vld));
            check("cmp_rd_data",  int'(rd_data),     int'(m_data));
            check("count_le_depth", int'(count <= 5'(DEPTH)), 1);
`ifdef QAM_FIFO_ERR_FLAGS_EN
            check("cmp_overflow",  int'(overflow),  int'(m_ovf));
            check("cmp_underflow", int'(underflow), int'(m_unf));
`endif
        end
    end

    // Drive one cycle of requests, then return 1 time unit after the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_empty", int'(empty), 1);
        check("reset_count", int'(count), 0);
        check("reset_rd_valid", int'(rd_valid), 0);
        check("reset_rd_data", int'(rd_data), 0);
        rst_n = 1'b1;

        // Fill with 0..15.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0);
            check("fill_afull", int'(almost_full), int'(i + 1 >= 12));
        end
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 16);

        // 17th write while full is dropped.
        step(1'b1, 6'h3F, 1'b0);
        check("ovf_count", int'(count), 16);
`ifdef QAM_FIFO_ERR_FLAGS_EN
        check("ovf_flag", int'(overflow), 1);
`endif

        // Drain: 0..15 in order at one-cycle latency.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            check("drain_valid", int'(rd_valid), 1);
            check("drain_data", int'(rd_data), i);
        end
        check("drain_empty", int'(empty), 1);
        step(1'b0, '0, 1'b0);
        check("idle_valid", int'(rd_valid), 0);
        check("idle_hold", int'(rd_data), 15);

        // Read while empty.
        step(1'b0, '0, 1'b1);
        check("unf_valid", int'(rd_valid), 0);
        check("unf_hold", int'(rd_data), 15);
`ifdef QAM_FIFO_ERR_FLAGS_EN
        check("unf_flag", int'(underflow), 1);
        check("ovf_sticky", int'(overflow), 1);
`endif

        // Simultaneous at empty: only the write lands.
        step(1'b1, 6'h21, 1'b1);
        check("sim_empty_count", int'(count), 1);
        check("sim_empty_valid", int'(rd_valid), 0);

        // Simultaneous at count 5: count unchanged, oldest symbol comes out.
        for (int i = 0; i < 4; i++) step(1'b1, DW'(40 + i), 1'b0);
        check("pre_sim5_count", int'(count), 5);
        step(1'b1, 6'h0A, 1'b1);
        check("sim5_count", int'(count), 5);
        check("sim5_data", int'(rd_data), 'h21);

        // Simultaneous at full: only the read lands.
        while (count < 5'(DEPTH)) step(1'b1, DW'($urandom_range(0, 63)), 1'b0);
        step(1'b1, 6'h15, 1'b1);
        check("sim_full_count", int'(count), 15);
        check("sim_full_data", int'(rd_data), 40);

        // Random traffic across pointer rollover.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 55), DW'($urandom_range(0, 63)),
                 1'($urandom_range(0, 99) < 50));
        end
        // Forty interleaved write/read pairs.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, DW'($urandom_range(0, 63)), 1'b0);
            step(1'b0, '0, 1'b1);
        end

        // Reset in the middle of a burst.
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom_range(0, 63)), 1'b0);
        wr_en   = 1'b1;
        wr_data = 6'h11;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_empty", int'(empty), 1);
        check("midrst_count", int'(count), 0);
        check("midrst_valid", int'(rd_valid), 0);
        wr_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, '0, 1'b1);
        check("postrst_valid", int'(rd_valid), 0);
        check("postrst_count", int'(count), 0);
        step(1'b0, '0, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_qam_symbol_fifo
